// File: rtl/relu_layer_sched.sv
// relu_layer_sched
// Sequences one fully connected layer pass over a shared 8-input adder tree.
// For each output channel 0..NUM_CH-1 the block requests one vector of eight
// signed products. It sums the vector in a two-stage pipeline, adds the
// channel bias from a programmable table, applies ReLU and hands the
// activation downstream.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse, begins a layer pass (IDLE only)
//   busy                  high while the pass is running or draining
//   done                  one-cycle pulse after the last activation is taken
//   cfg_we/addr/bias      bias table write port (IDLE only)
//   in_valid/in_ready     product vector handshake
//   in_ch                 channel index of the vector requested next
//   din0..din7            signed products, DW bits each
//   out_valid/out_ready   activation handshake
//   out_ch, out_last      channel of dout, high on the final channel
//   dout                  ReLU activation, never negative
module relu_layer_sched #(
  parameter int NUM_CH = 8,
  parameter int DW     = 16,
  parameter int BW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [BW-1:0] cfg_bias,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [2:0]    in_ch,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  input  logic [DW-1:0] din4,
  input  logic [DW-1:0] din5,
  input  logic [DW-1:0] din6,
  input  logic [DW-1:0] din7,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_ch,
  output logic [DW-1:0] dout,
  output logic          out_last
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  // Power-on / reset contents of the bias table.
  function automatic logic [BW-1:0] default_bias(input logic [2:0] idx);
    logic [BW-1:0] b;
    case (idx)
      3'd0:    b = BW'(8'd23);
      3'd1:    b = BW'(8'd27);
      3'd2:    b = BW'(8'd10);
      3'd3:    b = BW'(8'd31);
      3'd4:    b = BW'(8'd20);
      3'd5:    b = BW'(8'd23);
      3'd6:    b = BW'(8'd35);
      3'd7:    b = BW'(8'd6);
      default: b = BW'(8'd0);
    endcase
    return b;
  endfunction

  // ReLU on a wrapped two's complement value.
  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
    return v[DW-1] ? {DW{1'b0}} : v;
  endfunction

  state_t        state_r;
  logic [2:0]    ch_cnt_r;
  logic          busy_r;
  logic          done_r;
  logic [BW-1:0] bias_r [0:7];

  logic          v1_r;
  logic [DW-1:0] s0_r;
  logic [DW-1:0] s1_r;
  logic [2:0]    ch1_r;

  logic          out_valid_r;
  logic [DW-1:0] dout_r;
  logic [2:0]    out_ch_r;
  logic          out_last_r;

  logic          adv_s;
  logic          in_ready_s;
  logic          in_fire_s;
  logic          out_fire_s;
  logic [DW-1:0] s0_s;
  logic [DW-1:0] s1_s;
  logic [DW-1:0] bias_ext_s;
  logic [DW-1:0] sum_s;

  // Pipeline advance and handshake qualifiers; in_ready must react to a
  // downstream stall in the same cycle, so it is combinational through adv.
  always_comb begin
    adv_s      = !out_valid_r || out_ready;
    in_ready_s = (state_r == ST_RUN) && adv_s;
    in_fire_s  = in_valid && in_ready_s;
    out_fire_s = out_valid_r && out_ready;
  end

  // Adder tree halves and the stage-2 sum; all adds wrap modulo 2^DW.
  always_comb begin
    s0_s       = din0 + din1 + din2 + din3;
    s1_s       = din4 + din5 + din6 + din7;
    bias_ext_s = {{(DW-BW){bias_r[ch1_r][BW-1]}}, bias_r[ch1_r]};
    sum_s      = s0_r + s1_r + bias_ext_s;
  end

  // Pass sequencer: state, channel counter, busy and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      ch_cnt_r <= 3'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r  <= ST_RUN;
            ch_cnt_r <= 3'd0;
            busy_r   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (in_fire_s) begin
            ch_cnt_r <= ch_cnt_r + 3'd1;
            if (ch_cnt_r == LAST_CH) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Only the final channel can still be in flight with out_last set.
          if (out_fire_s && out_last_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          ch_cnt_r <= 3'd0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  // Bias table; a write issued together with start still lands in IDLE,
  // well before any channel reaches stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        bias_r[i] <= default_bias(3'(i));
      end
    end else if (cfg_we && (state_r == ST_IDLE)) begin
      bias_r[cfg_addr] <= cfg_bias;
    end
  end

  // Stage 1: partial sums of the accepted vector; an empty slot is a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r  <= 1'b0;
      s0_r  <= {DW{1'b0}};
      s1_r  <= {DW{1'b0}};
      ch1_r <= 3'd0;
    end else if (adv_s) begin
      v1_r <= in_fire_s;
      if (in_fire_s) begin
        s0_r  <= s0_s;
        s1_r  <= s1_s;
        ch1_r <= ch_cnt_r;
      end
    end
  end

  // Stage 2: output register; data, channel and last flag move together
  // and hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      dout_r      <= {DW{1'b0}};
      out_ch_r    <= 3'd0;
      out_last_r  <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= v1_r;
      if (v1_r) begin
        dout_r     <= relu(sum_s);
        out_ch_r   <= ch1_r;
        out_last_r <= (ch1_r == LAST_CH);
      end else begin
        out_last_r <= 1'b0;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign in_ready  = in_ready_s;
  assign in_ch     = ch_cnt_r;
  assign out_valid = out_valid_r;
  assign out_ch    = out_ch_r;
  assign dout      = dout_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_relu_layer_sched.sv
// Directed self-checking bench for relu_layer_sched. Each pass supplies one
// vector per channel and compares every activation with a hand-computed
// value, also watching handshake ordering, stall stability and done timing.
module tb_relu_layer_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_bias;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ch;
  logic [15:0] din_a [8];
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ch;
  logic [15:0] dout;
  logic        out_last;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] vec  [8][8];
  logic [15:0] expv [8];

  always #5 clk = ~clk;

  relu_layer_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bias(cfg_bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .din0(din_a[0]), .din1(din_a[1]), .din2(din_a[2]), .din3(din_a[3]),
    .din4(din_a[4]), .din5(din_a[5]), .din6(din_a[6]), .din7(din_a[7]),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .dout(dout), .out_last(out_last)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [15:0] v);
    for (int k = 0; k < 8; k++) vec[ch][k] = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_in_ch"}, 32'(in_ch), 32'd0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_out_ch"}, 32'(out_ch), 32'd0);
    check_eq({tag, "_dout"}, 32'(dout), 32'd0);
    check_eq({tag, "_out_last"}, 32'(out_last), 32'd0);
  endtask

  // One full layer pass against vec/expv.
  task automatic run_pass(input string tag, input int gap_pct, input bit toggle,
                          input bit cfg_start, input logic [7:0] cfg_b,
                          input bit cfg_run, input bit timing);
    int sent = 0;
    int got = 0;
    int acc_cyc = 0;
    bit expect_done = 1'b0;
    bit finished = 1'b0;
    bit stalled = 1'b0;
    logic [15:0] h_dout = 16'd0;
    logic [2:0]  h_ch = 3'd0;
    logic        h_last = 1'b0;

    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    if (cfg_start) begin
      cfg_we = 1'b1;
      cfg_addr = 3'd2;
      cfg_bias = cfg_b;
    end
    @(negedge clk);
    start = 1'b0;
    cfg_we = 1'b0;
    #1;
    check_eq({tag, "_busy_start"}, 32'(busy), 32'd1);

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      cfg_we    = cfg_run && !expect_done;
      cfg_addr  = 3'd2;
      cfg_bias  = 8'd0;
      out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      in_valid  = (sent < 8) && ($urandom_range(99) >= gap_pct);
      for (int k = 0; k < 8; k++) din_a[k] = (sent < 8) ? vec[sent][k] : 16'd0;
      #1;
      if (expect_done) begin
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
        // Last accept edge follows cycle acc_cyc; done is registered two edges later.
        if (timing) check_eq({tag, "_done_lat"}, 32'(cyc - acc_cyc), 32'd3);
        finished = 1'b1;
      end else begin
        check_eq({tag, "_done_low"}, 32'(done), 32'd0);
        if (stalled) begin
          check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
          check_eq({tag, "_hold_dout"}, 32'(dout), 32'(h_dout));
          check_eq({tag, "_hold_ch"}, 32'(out_ch), 32'(h_ch));
          check_eq({tag, "_hold_last"}, 32'(out_last), 32'(h_last));
        end
        stalled = out_valid && !out_ready;
        if (stalled) begin
          h_dout = dout;
          h_ch = out_ch;
          h_last = out_last;
          check_eq({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        if (out_valid && out_ready) begin
          check_eq({tag, "_out_ch"}, 32'(out_ch), 32'(got));
          check_eq({tag, "_dout"}, 32'(dout), 32'(expv[got]));
          check_eq({tag, "_out_last"}, 32'(out_last), 32'(got == 7));
          if (got == 7) expect_done = 1'b1;
          got++;
        end
        if (in_valid && in_ready) begin
          check_eq({tag, "_in_ch"}, 32'(in_ch), 32'(sent));
          sent++;
          acc_cyc = cyc;
        end
      end
      @(negedge clk);
    end
    if (!finished) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    in_valid = 1'b0;
    cfg_we = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int acc;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = 3'd0;
    cfg_bias = 8'd0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) din_a[k] = 16'd0;

    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Default biases, all products 1.
    for (int c = 0; c < 8; c++) set_ch(c, 16'd1);
    expv = '{16'd31, 16'd35, 16'd18, 16'd39, 16'd28, 16'd31, 16'd43, 16'd14};
    run_pass("ones", 0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // Distinct products per lane (sum 255), backpressure and input gaps.
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 8; k++) vec[c][k] = 16'(1 << k);
    expv = '{16'd278, 16'd282, 16'd265, 16'd286, 16'd275, 16'd278, 16'd290, 16'd261};
    run_pass("bp", 30, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

    // ReLU clamping and modulo-2^16 wrap.
    set_ch(0, 16'hFFF6);
    set_ch(1, 16'h0000);
    set_ch(2, 16'h0000);
    set_ch(3, 16'h0000);
    set_ch(4, 16'h0000);
    set_ch(5, 16'h1000);
    set_ch(6, 16'hFFFC);
    set_ch(7, 16'h0FFF);
    expv = '{16'd0, 16'd27, 16'd10, 16'd31, 16'd20, 16'd0, 16'd3, 16'd32766};
    run_pass("relu_wrap", 0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    // Bias -128 on ch2 written with start; writes during RUN are ignored.
    for (int c = 0; c < 8; c++) set_ch(c, 16'd20);
    expv = '{16'd183, 16'd187, 16'd32, 16'd191, 16'd180, 16'd183, 16'd195, 16'd166};
    run_pass("bias_wr", 0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0);
    run_pass("bias_keep", 10, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    // Reset after four accepted vectors.
    for (int c = 0; c < 8; c++) set_ch(c, 16'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) din_a[k] = 16'd1;
    acc = 0;
    n = 0;
    while (acc < 4 && n < 20) begin
      #1;
      if (in_valid && in_ready) acc++;
      @(negedge clk);
      n++;
    end
    check_eq("midrst_accepts", 32'(acc), 32'd4);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("midrst_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end

    // Fresh pass after reset uses the reloaded default biases.
    expv = '{16'd31, 16'd35, 16'd18, 16'd39, 16'd28, 16'd31, 16'd43, 16'd14};
    run_pass("after_rst", 0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
